hanoi_engine: RTL

- Parametrised Tower-of-Hanoi game core. It holds peg/disk occupancy for NUM_PEGS pegs and NUM_DISKS disks.
- It resolves "move top disk of peg S left/right" requests with a sequential candidate scan, counts legal moves and flags a win.
- It sits between the debounced button/switch front end and the display/blink logic, replacing the fixed 4x4 move decoder.

---
 rtl/hanoi_engine_if.sv | 22 ++
 rtl/hanoi_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hanoi_engine_if.sv
// Move-request handshake between the button front end (master) and the Hanoi game core (slave).
// The request is a single-cycle pulse. The core answers with a single-cycle ack/ok pair and holds busy while it scans.
interface hanoi_engine_if #(
   parameter int PW = 2
);
   logic          move_req;
   logic [PW-1:0] move_src;
   logic          move_dir;
   logic          move_ack;
   logic          move_ok;
   logic          busy;

   modport master (
      output move_req, move_src, move_dir,
      input  move_ack, move_ok, busy
   );

   modport slave (
      input  move_req, move_src, move_dir,
      output move_ack, move_ok, busy
   );
endinterface

// File: rtl/hanoi_engine.sv
// Tower-of-Hanoi game core: peg occupancy, sequential destination scan, move counter and win flag.
// A request moves the top disk of a source peg to the first legal peg found in the requested direction.
module hanoi_engine #(
   parameter int NUM_PEGS  = 4,
   parameter int NUM_DISKS = 4,
   parameter int CNT_W     = 16,
   parameter int WRAP      = 0,
   localparam int PW       = ($clog2(NUM_PEGS) < 1) ? 1 : $clog2(NUM_PEGS)
) (
   input  logic                          msclk,
   input  logic                          rst_n,
   input  logic                          restart,
   input  logic [PW-1:0]                 start_peg,
   hanoi_engine_if.slave                 mif,
   output logic [NUM_PEGS*NUM_DISKS-1:0] pegs,
   output logic [CNT_W-1:0]              move_count,
   output logic                          win
);

   typedef logic [NUM_DISKS-1:0] disk_vec_t;
   typedef disk_vec_t [NUM_PEGS-1:0] peg_arr_t;
   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [PW-1:0] LAST_PEG   = PW'(NUM_PEGS - 1);
   localparam peg_arr_t      RESET_PEGS = {{NUM_DISKS{1'b1}}, {((NUM_PEGS - 1) * NUM_DISKS){1'b0}}};

   // Peg indices are PW bits wide and may encode values past the last peg, so all lookups go through a decode loop.
   function automatic logic in_range(input logic [PW-1:0] idx);
      logic r;
      r = 1'b0;
      for (int p = 0; p < NUM_PEGS; p++) begin
         if (idx == PW'(p)) r = 1'b1;
      end
      return r;
   endfunction

   function automatic disk_vec_t peg_of(input peg_arr_t arr, input logic [PW-1:0] idx);
      disk_vec_t r;
      r = '0;
      for (int p = 0; p < NUM_PEGS; p++) begin
         if (idx == PW'(p)) r = arr[p];
      end
      return r;
   endfunction

   function automatic logic at_edge(input logic [PW-1:0] idx, input logic dir);
      return dir ? (idx == LAST_PEG) : (idx == '0);
   endfunction

   function automatic logic [PW-1:0] step(input logic [PW-1:0] idx, input logic dir);
      logic [PW-1:0] r;
      if (dir) r = (idx == LAST_PEG) ? '0 : idx + 1'b1;
      else     r = (idx == '0) ? LAST_PEG : idx - 1'b1;
      return r;
   endfunction

   state_t          state_q, state_d;
   logic [PW-1:0]   src_q, src_d;
   logic [PW-1:0]   cand_q, cand_d;
   logic            dir_q, dir_d;
   disk_vec_t       disk_q, disk_d;
   peg_arr_t        pegs_q, pegs_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic            win_q, win_d;
   logic            busy_q, busy_d;
   logic            ack_q, ack_d;
   logic            ok_q, ok_d;

   disk_vec_t       src_peg, src_top, cand_peg;
   logic            cand_legal, scan_exhausted;
   logic [PW-1:0]   start_idx;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      cand_d  = cand_q;
      dir_d   = dir_q;
      disk_d  = disk_q;
      pegs_d  = pegs_q;
      count_d = count_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      ok_d    = 1'b0;
      // Win is judged on the already-committed state, so it rises one edge after the winning move.
      win_d   = win_q | ((pegs_q[0] == {NUM_DISKS{1'b1}}) && (count_q != '0));

      src_peg    = peg_of(pegs_q, mif.move_src);
      src_top    = src_peg & (~src_peg + 1'b1);
      cand_peg   = peg_of(pegs_q, cand_q);
      cand_legal = (cand_peg & (disk_q | (disk_q - 1'b1))) == '0;
      scan_exhausted = (WRAP == 0) ? at_edge(cand_q, dir_q) : (step(cand_q, dir_q) == src_q);
      start_idx  = in_range(start_peg) ? start_peg : LAST_PEG;

      if (restart) begin
         pegs_d = '0;
         for (int p = 0; p < NUM_PEGS; p++) begin
            if (start_idx == PW'(p)) pegs_d[p] = {NUM_DISKS{1'b1}};
         end
         count_d = '0;
         win_d   = 1'b0;
         busy_d  = 1'b0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (mif.move_req) begin
                  if (win_q || !in_range(mif.move_src) || (src_peg == '0) ||
                      ((WRAP == 0) && at_edge(mif.move_src, mif.move_dir))) begin
                     ack_d = 1'b1;
                  end else begin
                     src_d   = mif.move_src;
                     dir_d   = mif.move_dir;
                     disk_d  = src_top;
                     cand_d  = step(mif.move_src, mif.move_dir);
                     busy_d  = 1'b1;
                     state_d = SCAN;
                  end
               end
            end
            SCAN: begin
               if (cand_legal) begin
                  for (int p = 0; p < NUM_PEGS; p++) begin
                     if (src_q == PW'(p))  pegs_d[p] = pegs_d[p] & ~disk_q;
                     if (cand_q == PW'(p)) pegs_d[p] = pegs_d[p] | disk_q;
                  end
                  if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
                  ack_d   = 1'b1;
                  ok_d    = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else if (scan_exhausted) begin
                  ack_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  cand_d = step(cand_q, dir_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge msclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         cand_q  <= '0;
         dir_q   <= 1'b0;
         disk_q  <= '0;
         pegs_q  <= RESET_PEGS;
         count_q <= '0;
         win_q   <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         cand_q  <= cand_d;
         dir_q   <= dir_d;
         disk_q  <= disk_d;
         pegs_q  <= pegs_d;
         count_q <= count_d;
         win_q   <= win_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         ok_q    <= ok_d;
      end
   end

   assign pegs         = pegs_q;
   assign move_count   = count_q;
   assign win          = win_q;
   assign mif.move_ack = ack_q;
   assign mif.move_ok  = ok_q;
   assign mif.busy     = busy_q;

endmodule
